branch_resolve: RTL and testbench

//   Consumer of the signed compare flags (more/equal/less) in the pipelined MIPS core.

---
 rtl/branch_resolve_if.sv | 30 +++
 rtl/branch_resolve.sv | 121 ++++++++++++
 tb/tb_branch_resolve.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_if.sv
// Branch request/redirect bundle between decode, the resolver and fetch.
interface branch_resolve_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  br_valid;
  logic                  br_ready;
  logic [2:0]            br_type;
  logic                  more;
  logic                  equal;
  logic                  less;
  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic [15:0]           offset;
  logic                  jump_valid;
  logic [ADDR_WIDTH-1:0] jump_target;
  logic                  flush;
  logic                  flag_err;
  logic [CNT_WIDTH-1:0]  branch_cnt;
  logic [CNT_WIDTH-1:0]  taken_cnt;

  modport master (
    output br_valid, br_type, more, equal, less, pc_plus4, offset,
    input  br_ready, jump_valid, jump_target, flush, flag_err, branch_cnt, taken_cnt
  );

  modport slave (
    input  br_valid, br_type, more, equal, less, pc_plus4, offset,
    output br_ready, jump_valid, jump_target, flush, flag_err, branch_cnt, taken_cnt
  );
endinterface

// File: rtl/branch_resolve.sv
// Resolves branches from compare flags; redirect 1 cycle after accept, then flush for FLUSH_CYCLES.
// br_ready is low from the redirect cycle through the last flush cycle; upstream must hold its request.
module branch_resolve #(
  parameter int ADDR_WIDTH   = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  branch_resolve_if.slave br
);

  typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_t;

  state_t                state_q;
  logic                  ready_q;
  logic                  jump_valid_q;
  logic                  flush_q;
  logic                  flag_err_q;
  logic [ADDR_WIDTH-1:0] jump_target_q;
  logic [CNT_WIDTH-1:0]  branch_cnt_q;
  logic [CNT_WIDTH-1:0]  taken_cnt_q;
  logic [3:0]            fcnt_q;

  logic                  accept;
  logic                  flags_ok;
  logic                  cond_d;
  logic                  taken_d;
  logic                  flag_err_d;
  logic [ADDR_WIDTH-1:0] target_d;

  assign accept = br.br_valid & ready_q;

  always_comb begin
    flags_ok = ({br.more, br.equal, br.less} == 3'b100) ||
               ({br.more, br.equal, br.less} == 3'b010) ||
               ({br.more, br.equal, br.less} == 3'b001);
    cond_d = 1'b0;
    case (br.br_type)
      3'b000:  cond_d = br.equal;
      3'b001:  cond_d = !br.equal;
      3'b010:  cond_d = br.less | br.equal;
      3'b011:  cond_d = br.more;
      3'b100:  cond_d = br.less;
      3'b101:  cond_d = br.more | br.equal;
      3'b110:  cond_d = 1'b1;
      default: cond_d = 1'b0;
    endcase
    taken_d    = cond_d & flags_ok;
    flag_err_d = !flags_ok | (br.br_type == 3'b111);
    // Word offset: sign-extend, scale by 4, wrap at ADDR_WIDTH.
    target_d   = br.pc_plus4 + {{(ADDR_WIDTH-18){br.offset[15]}}, br.offset, 2'b00};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ready_q       <= 1'b1;
      jump_valid_q  <= 1'b0;
      flush_q       <= 1'b0;
      flag_err_q    <= 1'b0;
      jump_target_q <= '0;
      branch_cnt_q  <= '0;
      taken_cnt_q   <= '0;
      fcnt_q        <= '0;
    end else begin
      flag_err_q   <= 1'b0;
      jump_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            flag_err_q <= flag_err_d;
            if (~&branch_cnt_q) branch_cnt_q <= branch_cnt_q + CNT_WIDTH'(1);
            if (taken_d) begin
              if (~&taken_cnt_q) taken_cnt_q <= taken_cnt_q + CNT_WIDTH'(1);
              state_q       <= REDIRECT;
              ready_q       <= 1'b0;
              jump_valid_q  <= 1'b1;
              jump_target_q <= target_d;
              flush_q       <= 1'b1;
            end
          end
        end
        REDIRECT: begin
          if (FLUSH_CYCLES > 1) begin
            // Remaining FLUSH-state cycles after the first one.
            state_q <= FLUSH;
            fcnt_q  <= 4'(FLUSH_CYCLES - 2);
          end else begin
            state_q <= IDLE;
            flush_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        FLUSH: begin
          if (fcnt_q == 4'd0) begin
            state_q <= IDLE;
            flush_q <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            fcnt_q <= fcnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          flush_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign br.br_ready    = ready_q;
  assign br.jump_valid  = jump_valid_q;
  assign br.jump_target = jump_target_q;
  assign br.flush       = flush_q;
  assign br.flag_err    = flag_err_q;
  assign br.branch_cnt  = branch_cnt_q;
  assign br.taken_cnt   = taken_cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: vector table, hand sequences, randomized model check, saturation.
module tb_branch_resolve;

  localparam int F0 = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  branch_resolve_if #(.ADDR_WIDTH(32), .CNT_WIDTH(16)) bi0 ();
  branch_resolve_if #(.ADDR_WIDTH(32), .CNT_WIDTH(4))  bi1 ();

  branch_resolve #(.ADDR_WIDTH(32), .FLUSH_CYCLES(F0), .CNT_WIDTH(16)) u0 (
    .clk(clk), .rst_n(rst_n), .br(bi0)
  );
  branch_resolve #(.ADDR_WIDTH(32), .FLUSH_CYCLES(1), .CNT_WIDTH(4)) u1 (
    .clk(clk), .rst_n(rst_n), .br(bi1)
  );

  // Reference state for u0
  int          m_bcnt = 0;
  int          m_tcnt = 0;
  logic [31:0] m_tgt  = '0;

  typedef struct {
    logic [2:0]  t;
    logic        m, e, l;
    logic [31:0] pc;
    logic [15:0] off;
    logic        xt, xe;
    logic [31:0] xtgt;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Taken/err from the signed relation the flags encode.
  function automatic logic [1:0] ref_eval(input logic [2:0] t, input logic m, e, l);
    int  c;
    logic tk;
    if ((int'(m) + int'(e) + int'(l)) != 1) return 2'b01;
    if (t == 3'd7) return 2'b01;
    c = m ? 1 : (l ? -1 : 0);
    case (t)
      3'd0: tk = (c == 0);
      3'd1: tk = (c != 0);
      3'd2: tk = (c <= 0);
      3'd3: tk = (c > 0);
      3'd4: tk = (c < 0);
      3'd5: tk = (c >= 0);
      default: tk = 1'b1;
    endcase
    return {tk, 1'b0};
  endfunction

  function automatic logic [31:0] ref_tgt(input logic [31:0] pc, input logic [15:0] off);
    int so;
    so = $signed(off);
    return pc + 32'(so * 4);
  endfunction

  task automatic drive0(input logic v, input logic [2:0] t, input logic m, e, l,
                        input logic [31:0] pc, input logic [15:0] off);
    bi0.br_valid = v; bi0.br_type = t;
    bi0.more = m; bi0.equal = e; bi0.less = l;
    bi0.pc_plus4 = pc; bi0.offset = off;
  endtask

  task automatic do_branch(input string nm, input logic [2:0] t, input logic m, e, l,
                           input logic [31:0] pc, input logic [15:0] off,
                           input logic xt, xe, input logic [31:0] xtgt);
    chk({nm, " ready_pre"}, 64'(bi0.br_ready), 64'(1));
    drive0(1'b1, t, m, e, l, pc, off);
    step();
    bi0.br_valid = 1'b0;
    m_bcnt++;
    if (xt) begin
      m_tcnt++;
      m_tgt = xtgt;
    end
    chk({nm, " jv"},     64'(bi0.jump_valid),  64'(xt));
    chk({nm, " flush"},  64'(bi0.flush),       64'(xt));
    chk({nm, " ready"},  64'(bi0.br_ready),    64'(!xt));
    chk({nm, " err"},    64'(bi0.flag_err),    64'(xe));
    chk({nm, " tgt"},    64'(bi0.jump_target), 64'(m_tgt));
    chk({nm, " bcnt"},   64'(bi0.branch_cnt),  64'(m_bcnt));
    chk({nm, " tcnt"},   64'(bi0.taken_cnt),   64'(m_tcnt));
    if (xt) begin
      for (int k = 1; k < F0; k++) begin
        step();
        chk({nm, " jv_off"},    64'(bi0.jump_valid), 64'(0));
        chk({nm, " flush_hi"},  64'(bi0.flush),      64'(1));
        chk({nm, " ready_lo"},  64'(bi0.br_ready),   64'(0));
        chk({nm, " err_off"},   64'(bi0.flag_err),   64'(0));
      end
      step();
      chk({nm, " flush_end"}, 64'(bi0.flush),       64'(0));
      chk({nm, " ready_end"}, 64'(bi0.br_ready),    64'(1));
      chk({nm, " tgt_hold"},  64'(bi0.jump_target), 64'(m_tgt));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  r;
    logic [2:0]  t;
    logic [2:0]  f;
    logic [31:0] pc;
    logic [15:0] off;
    int          s;

    tbl[0]  = '{3'd0, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 16'h0004, 1'b1, 1'b0, 32'h0000_0110};
    tbl[1]  = '{3'd1, 1'b0, 1'b1, 1'b0, 32'h0000_0200, 16'h0008, 1'b0, 1'b0, 32'h0};
    tbl[2]  = '{3'd5, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 16'hFFFF, 1'b1, 1'b0, 32'hFFFF_FFFC};
    tbl[3]  = '{3'd4, 1'b1, 1'b0, 1'b0, 32'h0000_0300, 16'h0010, 1'b0, 1'b0, 32'h0};
    tbl[4]  = '{3'd6, 1'b1, 1'b0, 1'b1, 32'h0000_0400, 16'h0010, 1'b0, 1'b1, 32'h0};
    tbl[5]  = '{3'd7, 1'b0, 1'b1, 1'b0, 32'h0000_0500, 16'h0010, 1'b0, 1'b1, 32'h0};
    tbl[6]  = '{3'd2, 1'b0, 1'b0, 1'b1, 32'h0000_1000, 16'hFFFE, 1'b1, 1'b0, 32'h0000_0FF8};
    tbl[7]  = '{3'd3, 1'b0, 1'b1, 1'b0, 32'h0000_0600, 16'h0010, 1'b0, 1'b0, 32'h0};
    tbl[8]  = '{3'd2, 1'b0, 1'b1, 1'b0, 32'h0000_0200, 16'h0010, 1'b1, 1'b0, 32'h0000_0240};
    tbl[9]  = '{3'd6, 1'b0, 1'b0, 1'b0, 32'h0000_0700, 16'h0010, 1'b0, 1'b1, 32'h0};
    tbl[10] = '{3'd3, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 16'h0001, 1'b1, 1'b0, 32'h0000_0000};

    drive0(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0);
    bi1.br_valid = 1'b0; bi1.br_type = 3'd6;
    bi1.more = 1'b0; bi1.equal = 1'b1; bi1.less = 1'b0;
    bi1.pc_plus4 = '0; bi1.offset = '0;

    // Reset state
    step(); step();
    chk("rst ready", 64'(bi0.br_ready),    64'(1));
    chk("rst jv",    64'(bi0.jump_valid),  64'(0));
    chk("rst flush", 64'(bi0.flush),       64'(0));
    chk("rst err",   64'(bi0.flag_err),    64'(0));
    chk("rst tgt",   64'(bi0.jump_target), 64'(0));
    chk("rst bcnt",  64'(bi0.branch_cnt),  64'(0));
    chk("rst tcnt",  64'(bi0.taken_cnt),   64'(0));
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 11; i++)
      do_branch($sformatf("vec%0d", i), tbl[i].t, tbl[i].m, tbl[i].e, tbl[i].l,
                tbl[i].pc, tbl[i].off, tbl[i].xt, tbl[i].xe, tbl[i].xtgt);

    // BNE equal=1 on three consecutive cycles
    drive0(1'b1, 3'd1, 1'b0, 1'b1, 1'b0, 32'h0000_0800, 16'h0020);
    for (int i = 0; i < 3; i++) begin
      step();
      m_bcnt++;
      chk("b2b jv",    64'(bi0.jump_valid), 64'(0));
      chk("b2b flush", 64'(bi0.flush),      64'(0));
      chk("b2b ready", 64'(bi0.br_ready),   64'(1));
      chk("b2b bcnt",  64'(bi0.branch_cnt), 64'(m_bcnt));
      chk("b2b tcnt",  64'(bi0.taken_cnt),  64'(m_tcnt));
    end
    bi0.br_valid = 1'b0;

    // Request held while busy is only taken once ready returns
    drive0(1'b1, 3'd6, 1'b0, 1'b1, 1'b0, 32'h0000_0900, 16'h0003);
    step();
    m_bcnt++; m_tcnt++; m_tgt = 32'h0000_090C;
    drive0(1'b1, 3'd1, 1'b0, 1'b1, 1'b0, 32'h0000_0A00, 16'h0001);
    chk("hold jv",  64'(bi0.jump_valid),  64'(1));
    chk("hold tgt", 64'(bi0.jump_target), 64'(m_tgt));
    for (int i = 0; i < F0; i++) begin
      if (i > 0) begin
        chk("hold flush", 64'(bi0.flush),    64'(1));
        chk("hold ready", 64'(bi0.br_ready), 64'(0));
      end
      step();
      chk("hold bcnt", 64'(bi0.branch_cnt), 64'(m_bcnt));
    end
    chk("hold ready_back", 64'(bi0.br_ready), 64'(1));
    step();
    bi0.br_valid = 1'b0;
    m_bcnt++;
    chk("hold bcnt_acc", 64'(bi0.branch_cnt), 64'(m_bcnt));
    chk("hold jv_nt",    64'(bi0.jump_valid), 64'(0));

    // Reset during second flush cycle
    drive0(1'b1, 3'd6, 1'b0, 1'b1, 1'b0, 32'h0000_0B00, 16'h0001);
    step();
    bi0.br_valid = 1'b0;
    chk("mid flush1", 64'(bi0.flush), 64'(1));
    step();
    chk("mid flush2", 64'(bi0.flush), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("mid flush_async", 64'(bi0.flush),      64'(0));
    chk("mid jv_async",    64'(bi0.jump_valid), 64'(0));
    step();
    rst_n = 1'b1;
    m_bcnt = 0; m_tcnt = 0; m_tgt = '0;
    step();
    chk("mid ready", 64'(bi0.br_ready),   64'(1));
    chk("mid bcnt",  64'(bi0.branch_cnt), 64'(0));
    chk("mid tcnt",  64'(bi0.taken_cnt),  64'(0));
    chk("mid tgt",   64'(bi0.jump_target), 64'(0));

    // Randomized against the reference model
    for (int i = 0; i < 60; i++) begin
      t   = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 4) == 0) f = 3'($urandom_range(0, 7));
      else f = 3'(1 << $urandom_range(0, 2));
      pc  = $urandom;
      off = 16'($urandom);
      r   = ref_eval(t, f[2], f[1], f[0]);
      do_branch($sformatf("rnd%0d", i), t, f[2], f[1], f[0], pc, off,
                r[1], r[0], ref_tgt(pc, off));
    end

    // Saturation on the 4-bit, single-flush-cycle instance
    s = 0;
    for (int i = 0; i < 17; i++) begin
      bi1.br_valid = 1'b1;
      bi1.pc_plus4 = 32'(i * 16);
      step();
      bi1.br_valid = 1'b0;
      s = (s < 15) ? s + 1 : 15;
      chk("sat jv",    64'(bi1.jump_valid),  64'(1));
      chk("sat tgt",   64'(bi1.jump_target), 64'(i * 16));
      chk("sat flush", 64'(bi1.flush),       64'(1));
      chk("sat bcnt",  64'(bi1.branch_cnt),  64'(s));
      chk("sat tcnt",  64'(bi1.taken_cnt),   64'(s));
      step();
      chk("sat flush_end", 64'(bi1.flush),    64'(0));
      chk("sat ready",     64'(bi1.br_ready), 64'(1));
    end
    chk("sat bcnt_final", 64'(bi1.branch_cnt), 64'(15));
    chk("sat tcnt_final", 64'(bi1.taken_cnt),  64'(15));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
